// File: rtl/tp_sched_pkg.sv
// Shared types for the testpattern scheduler: timing bundle,
// resolution presets, FSM states and small helpers.
package tp_sched_pkg;

    typedef struct packed {
        logic [15:0] h_total;
        logic [15:0] h_sync;
        logic [15:0] h_bporch;
        logic [15:0] h_res;
        logic [15:0] v_total;
        logic [15:0] v_sync;
        logic [15:0] v_bporch;
        logic [15:0] v_res;
        logic        hs_pol;
        logic        vs_pol;
    } tp_timing_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } tp_sched_state_e;

    // Entry 3 is reserved and aliases preset 0.
    localparam tp_timing_t TP_PRESET [0:3] = '{
        '{16'd1056, 16'd128, 16'd88,  16'd800,
          16'd628,  16'd4,   16'd23,  16'd600, 1'b1, 1'b1},
        '{16'd1344, 16'd136, 16'd160, 16'd1024,
          16'd806,  16'd6,   16'd29,  16'd768, 1'b0, 1'b0},
        '{16'd1650, 16'd40,  16'd220, 16'd1280,
          16'd750,  16'd5,   16'd20,  16'd720, 1'b1, 1'b1},
        '{16'd1056, 16'd128, 16'd88,  16'd800,
          16'd628,  16'd4,   16'd23,  16'd600, 1'b1, 1'b1}
    };

    // The reserved select behaves exactly like preset 0.
    function automatic logic [1:0] sel_norm(input logic [1:0] s);
        return (s == 2'd3) ? 2'd0 : s;
    endfunction

    // Next auto-cycle mode, wrapping after the highest mode.
    function automatic logic [2:0] mode_next(input logic [2:0] m,
                                             input logic [2:0] max);
        return (m >= max) ? 3'd0 : m + 3'd1;
    endfunction

endpackage

// File: rtl/tp_frame_det.sv
// Frame-start detector: registers vs and flags the cycle where it
// first reaches its active level.
module tp_frame_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    input  logic pol,
    output logic frame_start
);

    logic vs_q;

    // Previous vs level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) vs_q <= 1'b0;
        else        vs_q <= vs;
    end

    assign frame_start = (vs == pol) && (vs_q != pol);

endmodule

// File: rtl/tp_mode_scheduler.sv
// Frame-synchronous scheduler for testpattern timing and mode.
// Auto-cycling of modes is enabled by TP_SCHED_AUTO_CYCLE_EN.
module tp_mode_scheduler #(
    parameter int HOLD_CYC = 16,
    parameter int MODE_MAX = 2
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst_n,
    input  logic        I_res_req,
    input  logic [1:0]  I_res_sel,
    input  logic [7:0]  I_frames_per_mode,
    input  logic [2:0]  I_mode_man,
    input  logic        I_vs,
    output logic        O_gen_rst_n,
    output logic [2:0]  O_mode,
    output logic [15:0] O_h_total,
    output logic [15:0] O_h_sync,
    output logic [15:0] O_h_bporch,
    output logic [15:0] O_h_res,
    output logic [15:0] O_v_total,
    output logic [15:0] O_v_sync,
    output logic [15:0] O_v_bporch,
    output logic [15:0] O_v_res,
    output logic        O_hs_pol,
    output logic        O_vs_pol,
    output logic [1:0]  O_res_cur,
    output logic        O_busy
);
    import tp_sched_pkg::*;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);

    tp_sched_state_e state;
    tp_timing_t      tim;
    logic [15:0]     hold_cnt;
    logic [1:0]      pend_sel;
    logic [1:0]      req_sel;
    logic            hold_req;
    logic            frame_start;

    assign req_sel = sel_norm(I_res_sel);

    tp_frame_det u_frame_det (
        .clk         (I_pxl_clk),
        .rst_n       (I_rst_n),
        .vs          (I_vs),
        .pol         (tim.vs_pol),
        .frame_start (frame_start)
    );

    // Reload sequencing: RUN -> PEND -> (frame start) -> HOLD -> RUN/PEND.
    always_ff @(posedge I_pxl_clk) begin
        if (!I_rst_n) begin
            state       <= ST_HOLD;
            tim         <= TP_PRESET[0];
            hold_cnt    <= 16'd0;
            pend_sel    <= 2'd0;
            hold_req    <= 1'b0;
            O_res_cur   <= 2'd0;
            O_gen_rst_n <= 1'b0;
            O_busy      <= 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (I_res_req && req_sel != O_res_cur) begin
                        pend_sel <= req_sel;
                        state    <= ST_PEND;
                        O_busy   <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (frame_start) begin
                        // A request in the same cycle is the newest intent.
                        tim         <= TP_PRESET[I_res_req ? req_sel : pend_sel];
                        O_res_cur   <= I_res_req ? req_sel : pend_sel;
                        hold_cnt    <= 16'd0;
                        hold_req    <= 1'b0;
                        O_gen_rst_n <= 1'b0;
                        state       <= ST_HOLD;
                    end else if (I_res_req) begin
                        pend_sel <= req_sel;
                    end
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 16'd1;
                    if (I_res_req) begin
                        pend_sel <= req_sel;
                        hold_req <= 1'b1;
                    end
                    if (hold_cnt == HOLD_LAST) begin
                        O_gen_rst_n <= 1'b1;
                        if (hold_req || I_res_req) begin
                            state  <= ST_PEND;
                            O_busy <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            O_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

`ifdef TP_SCHED_AUTO_CYCLE_EN
    logic [7:0] frame_cnt;

    // Frame counter advancing the pattern mode every N frames in RUN.
    always_ff @(posedge I_pxl_clk) begin
        if (!I_rst_n) begin
            frame_cnt <= 8'd0;
            O_mode    <= 3'd0;
        end else if (state == ST_HOLD) begin
            frame_cnt <= 8'd0;
        end else if (state == ST_RUN && frame_start &&
                     I_frames_per_mode != 8'd0) begin
            if (frame_cnt >= I_frames_per_mode - 8'd1) begin
                frame_cnt <= 8'd0;
                O_mode    <= mode_next(O_mode, 3'(MODE_MAX));
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_fpm;
    assign unused_fpm = ^I_frames_per_mode;

    // Manual mode select, registered for a clean output.
    always_ff @(posedge I_pxl_clk) begin
        if (!I_rst_n) O_mode <= 3'd0;
        else          O_mode <= I_mode_man;
    end
`endif

    assign O_h_total  = tim.h_total;
    assign O_h_sync   = tim.h_sync;
    assign O_h_bporch = tim.h_bporch;
    assign O_h_res    = tim.h_res;
    assign O_v_total  = tim.v_total;
    assign O_v_sync   = tim.v_sync;
    assign O_v_bporch = tim.v_bporch;
    assign O_v_res    = tim.v_res;
    assign O_hs_pol   = tim.hs_pol;
    assign O_vs_pol   = tim.vs_pol;

endmodule

// File: tb/tb_tp_mode_scheduler.sv
// Directed bench for tp_mode_scheduler; mode checks follow
// whether TP_SCHED_AUTO_CYCLE_EN is defined.
module tb_tp_mode_scheduler;

    localparam int HOLD = 16;

    logic        I_pxl_clk = 1'b0;
    logic        I_rst_n;
    logic        I_res_req;
    logic [1:0]  I_res_sel;
    logic [7:0]  I_frames_per_mode;
    logic [2:0]  I_mode_man;
    logic        I_vs;
    logic        O_gen_rst_n;
    logic [2:0]  O_mode;
    logic [15:0] O_h_total, O_h_sync, O_h_bporch, O_h_res;
    logic [15:0] O_v_total, O_v_sync, O_v_bporch, O_v_res;
    logic        O_hs_pol, O_vs_pol;
    logic [1:0]  O_res_cur;
    logic        O_busy;

    int checks = 0;
    int errors = 0;

    tp_mode_scheduler #(.HOLD_CYC(HOLD), .MODE_MAX(2)) dut (
        .I_pxl_clk         (I_pxl_clk),
        .I_rst_n           (I_rst_n),
        .I_res_req         (I_res_req),
        .I_res_sel         (I_res_sel),
        .I_frames_per_mode (I_frames_per_mode),
        .I_mode_man        (I_mode_man),
        .I_vs              (I_vs),
        .O_gen_rst_n       (O_gen_rst_n),
        .O_mode            (O_mode),
        .O_h_total         (O_h_total),
        .O_h_sync          (O_h_sync),
        .O_h_bporch        (O_h_bporch),
        .O_h_res           (O_h_res),
        .O_v_total         (O_v_total),
        .O_v_sync          (O_v_sync),
        .O_v_bporch        (O_v_bporch),
        .O_v_res           (O_v_res),
        .O_hs_pol          (O_hs_pol),
        .O_vs_pol          (O_vs_pol),
        .O_res_cur         (O_res_cur),
        .O_busy            (O_busy)
    );

    always #5 I_pxl_clk = ~I_pxl_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge I_pxl_clk);
    endtask

    // Reset held for three edges; released after the last one.
    task automatic do_reset();
        I_rst_n = 1'b0;
        I_res_req = 1'b0;
        I_res_sel = 2'd0;
        I_frames_per_mode = 8'd0;
        I_mode_man = 3'd0;
        I_vs = 1'b0;
        tick(3);
    endtask

    // Inactive level for two cycles, then active; returns one edge later.
    task automatic vs_active(input logic pol);
        I_vs = ~pol;
        tick(2);
        I_vs = pol;
        tick(1);
    endtask

    // Low samples of O_gen_rst_n starting at the current sample.
    task automatic hold_len(output int n);
        n = 0;
        while (O_gen_rst_n !== 1'b1 && n < 100) begin
            n++;
            tick(1);
        end
    endtask

    task automatic request(input logic [1:0] sel);
        I_res_req = 1'b1;
        I_res_sel = sel;
        tick(1);
        I_res_req = 1'b0;
    endtask

    task automatic release_and_wait();
        int n;
        I_rst_n = 1'b1;
        hold_len(n);
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++; if (O_h_total !== 16'd1056) begin errors++;
            $display("FAIL rst_h_total: got %0d want 1056", O_h_total); end
        checks++; if (O_v_res !== 16'd600 || O_h_sync !== 16'd128) begin errors++;
            $display("FAIL rst_v_res: got %0d/%0d want 600/128", O_v_res, O_h_sync); end
        checks++; if ({O_res_cur, O_mode} !== 5'd0) begin errors++;
            $display("FAIL rst_cur_mode: got %0d/%0d want 0/0", O_res_cur, O_mode); end
        checks++; if ({O_gen_rst_n, O_busy} !== 2'b01) begin errors++;
            $display("FAIL rst_gen_busy: got %b%b want 01", O_gen_rst_n, O_busy); end
        // Generator reset rises HOLD edges after the last reset edge.
        I_rst_n = 1'b1;
        n = 0;
        while (O_gen_rst_n !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        checks++; if (n != HOLD) begin errors++;
            $display("FAIL rst_hold_len: got %0d want %0d", n, HOLD); end
        checks++; if (O_busy !== 1'b0 || O_mode !== 3'd0) begin errors++;
            $display("FAIL rst_exit: busy %b mode %0d want 0 0", O_busy, O_mode); end
    endtask

    task automatic test_res_change();
        int n;
        request(2'd2);
        checks++; if (O_busy !== 1'b1 || O_h_total !== 16'd1056) begin errors++;
            $display("FAIL chg_pend: busy %b h_total %0d want 1 1056", O_busy, O_h_total); end
        tick(3);
        checks++; if (O_h_total !== 16'd1056 || O_gen_rst_n !== 1'b1) begin errors++;
            $display("FAIL chg_wait: h_total %0d gen %b want 1056 1", O_h_total, O_gen_rst_n); end
        I_vs = 1'b1;
        checks++; if (O_h_total !== 16'd1056) begin errors++;
            $display("FAIL chg_pre_edge: got %0d want 1056", O_h_total); end
        tick(1);
        checks++; if (O_h_total !== 16'd1650 || O_v_res !== 16'd720) begin errors++;
            $display("FAIL chg_load: got %0d/%0d want 1650/720", O_h_total, O_v_res); end
        checks++; if (O_h_sync !== 16'd40 || O_v_total !== 16'd750 || O_res_cur !== 2'd2) begin
            errors++;
            $display("FAIL chg_fields: got %0d/%0d/%0d want 40/750/2",
                     O_h_sync, O_v_total, O_res_cur); end
        hold_len(n);
        checks++; if (n != HOLD) begin errors++;
            $display("FAIL chg_hold_len: got %0d want %0d", n, HOLD); end
        checks++; if (O_busy !== 1'b0) begin errors++;
            $display("FAIL chg_busy_end: got %b want 0", O_busy); end
        I_vs = 1'b0;
        tick(2);
    endtask

    task automatic test_overwrite();
        int n;
        do_reset();
        release_and_wait();
        request(2'd3);
        checks++; if (O_busy !== 1'b0) begin errors++;
            $display("FAIL ow_sel3_ignored: busy %b want 0", O_busy); end
        request(2'd1);
        tick(2);
        request(2'd2);
        tick(2);
        checks++; if (O_h_total !== 16'd1056 || O_busy !== 1'b1) begin errors++;
            $display("FAIL ow_pend: h_total %0d busy %b want 1056 1", O_h_total, O_busy); end
        vs_active(1'b1);
        checks++; if (O_h_total !== 16'd1650 || O_res_cur !== 2'd2 || O_vs_pol !== 1'b1) begin
            errors++;
            $display("FAIL ow_load: %0d cur %0d pol %b want 1650 2 1",
                     O_h_total, O_res_cur, O_vs_pol); end
        hold_len(n);
        checks++; if (n != HOLD || O_busy !== 1'b0) begin errors++;
            $display("FAIL ow_hold: len %0d busy %b want %0d 0", n, O_busy, HOLD); end
        vs_active(1'b1);
        checks++; if (O_gen_rst_n !== 1'b1 || O_h_total !== 16'd1650) begin errors++;
            $display("FAIL ow_once: gen %b h_total %0d want 1 1650", O_gen_rst_n, O_h_total); end
        request(2'd2);
        checks++; if (O_busy !== 1'b0) begin errors++;
            $display("FAIL same_busy: got %b want 0", O_busy); end
        vs_active(1'b1);
        checks++; if (O_gen_rst_n !== 1'b1) begin errors++;
            $display("FAIL same_no_reload: gen %b want 1", O_gen_rst_n); end
    endtask

    task automatic test_req_in_hold();
        int n;
        request(2'd0);
        vs_active(1'b1);
        checks++; if (O_h_total !== 16'd1056 || O_gen_rst_n !== 1'b0) begin errors++;
            $display("FAIL hreq_load0: %0d gen %b want 1056 0", O_h_total, O_gen_rst_n); end
        tick(3);
        request(2'd2);
        hold_len(n);
        checks++; if (O_busy !== 1'b1 || O_h_total !== 16'd1056) begin errors++;
            $display("FAIL hreq_pend: busy %b h_total %0d want 1 1056", O_busy, O_h_total); end
        vs_active(1'b1);
        checks++; if (O_h_total !== 16'd1650 || O_res_cur !== 2'd2) begin errors++;
            $display("FAIL hreq_load2: %0d cur %0d want 1650 2", O_h_total, O_res_cur); end
        hold_len(n);
        checks++; if (n != HOLD || O_busy !== 1'b0) begin errors++;
            $display("FAIL hreq_hold: len %0d busy %b want %0d 0", n, O_busy, HOLD); end
    endtask

`ifdef TP_SCHED_AUTO_CYCLE_EN
    task automatic test_mode();
        logic [2:0] exp;
        do_reset();
        I_frames_per_mode = 8'd3;
        release_and_wait();
        for (int f = 1; f <= 9; f++) begin
            vs_active(1'b1);
            exp = 3'((f / 3) % 3);
            checks++; if (O_mode !== exp) begin errors++;
                $display("FAIL auto_frame%0d: got %0d want %0d", f, O_mode, exp); end
        end
        I_frames_per_mode = 8'd0;
        for (int f = 0; f < 4; f++) vs_active(1'b1);
        checks++; if (O_mode !== 3'd0) begin errors++;
            $display("FAIL auto_freeze: got %0d want 0", O_mode); end
    endtask
`else
    task automatic test_mode();
        do_reset();
        release_and_wait();
        I_mode_man = 3'd5;
        checks++; if (O_mode !== 3'd0) begin errors++;
            $display("FAIL man_latency: got %0d want 0", O_mode); end
        tick(1);
        checks++; if (O_mode !== 3'd5) begin errors++;
            $display("FAIL man_5: got %0d want 5", O_mode); end
        I_mode_man = 3'd3;
        tick(1);
        checks++; if (O_mode !== 3'd3) begin errors++;
            $display("FAIL man_3: got %0d want 3", O_mode); end
        I_mode_man = 3'd0;
        tick(1);
    endtask
`endif

    task automatic test_simultaneous();
        int n;
        do_reset();
        I_frames_per_mode = 8'd1;
        release_and_wait();
        I_vs = 1'b0;
        tick(2);
        I_vs = 1'b1;
        request(2'd2);
        checks++; if (O_busy !== 1'b1 || O_h_total !== 16'd1056 || O_gen_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL sim_pend: busy %b h_total %0d gen %b want 1 1056 1",
                     O_busy, O_h_total, O_gen_rst_n); end
`ifdef TP_SCHED_AUTO_CYCLE_EN
        checks++; if (O_mode !== 3'd1) begin errors++;
            $display("FAIL sim_mode_adv: got %0d want 1", O_mode); end
`endif
        vs_active(1'b1);
        checks++; if (O_h_total !== 16'd1650 || O_gen_rst_n !== 1'b0) begin errors++;
            $display("FAIL sim_reload: %0d gen %b want 1650 0", O_h_total, O_gen_rst_n); end
`ifdef TP_SCHED_AUTO_CYCLE_EN
        checks++; if (O_mode !== 3'd1) begin errors++;
            $display("FAIL sim_mode_keep: got %0d want 1", O_mode); end
`endif
        hold_len(n);
        checks++; if (n != HOLD) begin errors++;
            $display("FAIL sim_hold_len: got %0d want %0d", n, HOLD); end
    endtask

    initial begin
        test_reset();
        test_res_change();
        test_overwrite();
        test_req_in_hold();
        test_mode();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
